// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver: FSM state
// encoding, shifter control opcodes and the default word width.
package serial_frame_pkg;

  localparam int WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_HOLD  = 2'd0,
    SH_LEFT  = 2'd1,
    SH_RIGHT = 2'd2,
    SH_CLEAR = 2'd3
  } shift_op_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Line-side and consumer-side signals of the serial frame receiver; the
// receiver takes the slave view, the driving environment the master view.
interface serial_frame_rx_if #(
  parameter int WIDTH = serial_frame_pkg::WIDTH_DEFAULT
);

  logic             bit_en;
  logic             sin;
  logic             msb_first;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;
  logic             clr_ovr;

  modport master (
    output bit_en, sin, msb_first, dout_ready, clr_ovr,
    input  dout, dout_valid, frame_err, overrun
  );

  modport slave (
    input  bit_en, sin, msb_first, dout_ready, clr_ovr,
    output dout, dout_valid, frame_err, overrun
  );

endinterface

// File: rtl/serial_frame_rx_shifter.sv
// Data-bit assembly register: holds, shifts the serial bit in from either
// end, or clears, as commanded by the receive FSM.
module frame_shifter
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  shift_op_t        op,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // NOTE: this is a plain register, not a memory array, so it is reset
  // like any other state bit; clocked state always uses <=.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      case (op)
        SH_LEFT:  q <= {q[WIDTH-2:0], din};
        SH_RIGHT: q <= {din, q[WIDTH-1:1]};
        SH_CLEAR: q <= '0;
        default:  q <= q;
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Strobed serial frame receiver (start, WIDTH data bits, stop) with a
// one-word valid/ready output buffer, frame-error pulse and sticky overrun.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  serial_frame_rx_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_q, msb_d;
  shift_op_t        sh_op;
  logic [WIDTH-1:0] shreg;
  logic             deliver, bad_stop;

  logic [WIDTH-1:0] dout_q;
  logic             valid_q, ferr_q, ovr_q;
  logic             consume;

  frame_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk (clk),
    .rst (rst),
    .op  (sh_op),
    .din (bus.sin),
    .q   (shreg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    sh_op    = SH_HOLD;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    if (bus.bit_en) begin
      case (state_q)
        IDLE: begin
          if (!bus.sin) begin
            state_d = DATA;
            cnt_d   = '0;
            msb_d   = bus.msb_first;
            sh_op   = SH_CLEAR;
          end
        end
        DATA: begin
          sh_op = msb_q ? SH_LEFT : SH_RIGHT;
          // The counter parks on the last index instead of wrapping.
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STOP: begin
          state_d  = IDLE;
          deliver  = bus.sin;
          bad_stop = !bus.sin;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign consume = valid_q && bus.dout_ready;

  // A delivery lands only if the buffer is empty or being drained on the
  // same edge; otherwise the new word is dropped and overrun is raised.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad_stop;
      if (deliver && (!valid_q || consume)) begin
        dout_q  <= shreg;
        valid_q <= 1'b1;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      if (deliver && valid_q && !bus.dout_ready) begin
        ovr_q <= 1'b1;
      end else if (bus.clr_ovr) begin
        ovr_q <= 1'b0;
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed vectors plus randomized
// frames compared each cycle against a word-level reference model.
module tb_serial_frame_rx;

  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_frame_rx_if #(.WIDTH(W)) bus ();

  serial_frame_rx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model of the output side, in terms of whole words.
  logic [W-1:0] m_dout  = '0;
  logic         m_valid = 1'b0;
  logic         m_ferr  = 1'b0;
  logic         m_ovr   = 1'b0;
  bit           rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: update the model from the inputs present at the edge, then
  // compare every output just after the edge.
  task automatic tick(input bit dlv, input bit bad, input logic [W-1:0] word);
    bit set_ovr;
    if (rand_mode) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      bus.clr_ovr    = ($urandom_range(0, 7) == 0);
    end
    if (rst) begin
      m_dout = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
    end else begin
      set_ovr = dlv && m_valid && !bus.dout_ready;
      m_ferr  = bad;
      if (dlv && !set_ovr) begin
        m_dout  = word;
        m_valid = 1'b1;
      end else if (m_valid && bus.dout_ready) begin
        m_valid = 1'b0;
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (bus.clr_ovr) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
    check("dout",       32'(bus.dout),       32'(m_dout));
    check("frame_err",  32'(bus.frame_err),  32'(m_ferr));
    check("overrun",    32'(bus.overrun),    32'(m_ovr));
  endtask

  // Random idle gap with bit_en low and junk on sin/msb_first, then one strobe.
  task automatic strobe(input bit s, input bit dlv, input bit bad,
                        input logic [W-1:0] word, input bit is_start,
                        input bit msb, input bit rdy_force);
    int gap;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      bus.bit_en    = 1'b0;
      bus.sin       = 1'($urandom_range(0, 1));
      bus.msb_first = 1'($urandom_range(0, 1));
      tick(1'b0, 1'b0, '0);
    end
    bus.bit_en    = 1'b1;
    bus.sin       = s;
    bus.msb_first = is_start ? msb : 1'($urandom_range(0, 1));
    if (rdy_force) bus.dout_ready = 1'b1;
    tick(dlv, bad, word);
    if (rdy_force) bus.dout_ready = 1'b0;
    bus.bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input bit msb,
                            input bit stop_ok, input bit rdy_stop);
    strobe(1'b0, 1'b0, 1'b0, '0, 1'b1, msb, 1'b0);
    for (int i = 0; i < W; i++)
      strobe(msb ? word[W-1-i] : word[i], 1'b0, 1'b0, '0, 1'b0, msb, 1'b0);
    strobe(stop_ok, stop_ok, !stop_ok, word, 1'b0, msb, rdy_stop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.bit_en = 1'b0;
    bus.dout_ready = 1'b0;
    bus.clr_ovr = 1'b0;
    tick(1'b0, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    bus.bit_en = 1'b0; bus.sin = 1'b1; bus.msb_first = 1'b0;
    bus.dout_ready = 1'b0; bus.clr_ovr = 1'b0;
    do_reset();
    check("rst_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout",  32'(bus.dout),       32'd0);
    check("rst_ovr",   32'(bus.overrun),    32'd0);

    // sin 0,1,0,1,1,0,1 MSB first
    send_frame(5'h16, 1'b1, 1'b1, 1'b0);
    check("msb_dout",  32'(bus.dout),       32'h16);
    check("msb_valid", 32'(bus.dout_valid), 32'd1);
    check("msb_ferr",  32'(bus.frame_err),  32'd0);

    // Same line sequence LSB first
    do_reset();
    send_frame(5'h0D, 1'b0, 1'b1, 1'b0);
    check("lsb_dout",  32'(bus.dout), 32'h0D);

    // Bad stop bit, then a good frame
    do_reset();
    send_frame(5'h16, 1'b1, 1'b0, 1'b0);
    check("ferr_pulse", 32'(bus.frame_err),  32'd1);
    check("ferr_valid", 32'(bus.dout_valid), 32'd0);
    tick(1'b0, 1'b0, '0);
    check("ferr_once",  32'(bus.frame_err),  32'd0);
    send_frame(5'h0D, 1'b0, 1'b1, 1'b0);
    check("after_err_dout", 32'(bus.dout), 32'h0D);

    // Overrun and clear
    do_reset();
    send_frame(5'h16, 1'b1, 1'b1, 1'b0);
    send_frame(5'h09, 1'b1, 1'b1, 1'b0);
    check("ovr_dout", 32'(bus.dout),    32'h16);
    check("ovr_set",  32'(bus.overrun), 32'd1);
    bus.clr_ovr = 1'b1;
    tick(1'b0, 1'b0, '0);
    bus.clr_ovr = 1'b0;
    check("ovr_clr",  32'(bus.overrun), 32'd0);

    // Consume on the same edge as the next delivery
    do_reset();
    send_frame(5'h16, 1'b1, 1'b1, 1'b0);
    send_frame(5'h09, 1'b0, 1'b1, 1'b1);
    check("swap_dout",  32'(bus.dout),       32'h09);
    check("swap_valid", 32'(bus.dout_valid), 32'd1);
    check("swap_ovr",   32'(bus.overrun),    32'd0);

    // Reset in the middle of a frame
    strobe(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_frame(5'h1F, 1'b1, 1'b1, 1'b0);
    check("rst_mid_dout", 32'(bus.dout),      32'h1F);
    check("rst_mid_ferr", 32'(bus.frame_err), 32'd0);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int idle;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        bus.bit_en = 1'b1;
        bus.sin    = 1'b1;
        tick(1'b0, 1'b0, '0);
      end
      send_frame(W'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) != 0), 1'b0);
    end
    rand_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
